decode_67b_64b: RTL and testbench
=================================

DECODE_67B_64B -- requirements
Module: decode_67B_64B

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 64, meaning the number of consecutive valid headers needed to declare lock.
REQ-002 SHALL have parameter WIN_LEN, default 64, meaning the length in valid words of the locked error-monitor window.
REQ-003 SHALL have parameter ERR_CNT, default 16, meaning the number of bad headers within one window that causes lock loss.
REQ-004 SHALL have parameter SLIP_WAIT, default 32, meaning the number of valid words ignored after each SLIP pulse.
REQ-005 SHALL have port USER_CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port SYSTEM_RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port DATA_IN, input, 67 bits: [66] inversion flag, [65:64] sync header, [63:0] payload.
REQ-008 SHALL have port DATA_IN_VALID, input, 1 bit: DATA_IN qualifier; the block does nothing on cycles where it is low.
REQ-009 SHALL have port DATA_OUT, output, 64 bits: decoded payload.
REQ-010 SHALL have port HEADER_OUT, output, 2 bits: copy of DATA_IN[65:64].
REQ-011 SHALL have port DATA_OUT_VALID, output, 1 bit: output qualifier.
REQ-012 SHALL have port BLOCK_LOCK, output, 1 bit: word-lock status.
REQ-013 SHALL have port SLIP, output, 1 bit: one-cycle request to the upstream gearbox to shift alignment by one bit.
REQ-014 SHALL have port HEADER_ERR, output, 1 bit: one-cycle pulse for each valid word whose header is 00 or 11.

Function
REQ-015 SHALL register all outputs, with 1-cycle latency from DATA_IN and DATA_IN_VALID.
REQ-016 SHALL set DATA_OUT to ~DATA_IN[63:0] when DATA_IN[66]=1, and to DATA_IN[63:0] otherwise.
REQ-017 SHALL update DATA_OUT and HEADER_OUT only on valid words, holding them otherwise.
REQ-018 SHALL assert DATA_OUT_VALID only when DATA_IN_VALID=1 and BLOCK_LOCK=1 in the same cycle, evaluated before this cycle's state update.
REQ-019 SHALL treat a header as valid when it is 01 or 10, and bad when it is 00 or 11.
REQ-020 SHALL implement a state machine with states HUNT, WAIT and LOCKED, entering HUNT on reset with the good-header count at 0.
REQ-021 SHALL in HUNT increment the count on each valid good header, and on reaching LOCK_CNT move to LOCKED with BLOCK_LOCK=1 on the next cycle.
REQ-022 SHALL in HUNT, on a valid bad header, pulse SLIP for one cycle, clear the count and move to WAIT.
REQ-023 SHALL in WAIT count SLIP_WAIT valid words with headers ignored and no further SLIP, then return to HUNT with count 0.
REQ-024 SHALL in LOCKED count valid words (window) and bad headers (errors); when errors reach ERR_CNT, deassert BLOCK_LOCK, pulse SLIP, and move to WAIT.
REQ-025 SHALL in LOCKED clear both counters when the window reaches WIN_LEN; if the last word of a window is the ERR_CNT-th error, lock loss takes precedence over the window clear.
REQ-026 SHALL size counters to hold their parameter value without wrap and saturate at that value.
REQ-027 SHALL assert HEADER_ERR in every state, including WAIT.

Reset
REQ-028 SHALL, while SYSTEM_RESET_N=0, immediately force DATA_OUT=0, HEADER_OUT=0, DATA_OUT_VALID=0, BLOCK_LOCK=0, SLIP=0, HEADER_ERR=0, state HUNT, and all counters 0.
REQ-029 SHALL, when reset is asserted mid-lock or mid-WAIT, discard all progress, and SHALL need a full LOCK_CNT good headers after release before relocking.

Configuration
REQ-030 SHALL, with macro DISPARITY_CHECK_EN defined, add parameter DISP_LIMIT (default 128) and output port DISP_ERR (1 bit, reset 0).
REQ-031 SHALL, in that configuration, keep a 16-bit signed running sum of 2*popcount(DATA_IN[66:0])-67, updated on valid words only while LOCKED.
REQ-032 SHALL pulse DISP_ERR for one cycle when the magnitude of the updated sum exceeds DISP_LIMIT, and SHALL clear the sum on every LOCKED entry and exit.
REQ-033 SHALL, with DISPARITY_CHECK_EN undefined, have neither the DISP_ERR port nor the disparity logic, with all other behaviour unchanged.

Verification
REQ-034 SHALL cover: 64 valid words with header 01 after reset -> BLOCK_LOCK=1 one cycle after the 64th word; DATA_OUT_VALID first high for word 65.
REQ-035 SHALL cover: locked, input {1,10,64'h0000_0000_FFFF_FFFF} -> DATA_OUT=64'hFFFF_FFFF_0000_0000, HEADER_OUT=10 one cycle later.
REQ-036 SHALL cover: in HUNT, header 11 on word 10 -> one SLIP pulse and HEADER_ERR; next 32 valid words with bad headers -> no SLIP; lock only after a further 64 good words.
REQ-037 SHALL cover: locked, 15 bad headers in one 64-word window -> lock held and counters cleared; 16 bad headers in the next window -> BLOCK_LOCK=0 and SLIP pulse.
REQ-038 SHALL cover: SYSTEM_RESET_N low for 1 cycle while locked with DATA_IN_VALID toggling -> all outputs 0 asynchronously, and relock after exactly 64 good words.
REQ-039 SHALL cover, with DISPARITY_CHECK_EN defined: locked, repeated {0,01,64'hFFFF_FFFF_FFFF_FFFF} -> sum +63 per word, DISP_ERR pulse on the 3rd word (189>128).

Source files
------------

// File: rtl/decode_67b_64b.sv
// 67b/64b word decoder with header-based block lock (HUNT/WAIT/LOCKED) and slip requests.
// Optional running-disparity monitor enabled by defining DISPARITY_CHECK_EN.
module decode_67b_64b #(
    parameter int LOCK_CNT  = 64,
    parameter int WIN_LEN   = 64,
    parameter int ERR_CNT   = 16,
    parameter int SLIP_WAIT = 32
`ifdef DISPARITY_CHECK_EN
    ,
    parameter int DISP_LIMIT = 128
`endif
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET_N,
    input  logic [66:0] DATA_IN,
    input  logic        DATA_IN_VALID,
    output logic [63:0] DATA_OUT,
    output logic [1:0]  HEADER_OUT,
    output logic        DATA_OUT_VALID,
    output logic        BLOCK_LOCK,
    output logic        SLIP,
    output logic        HEADER_ERR
`ifdef DISPARITY_CHECK_EN
    ,
    output logic        DISP_ERR
`endif
);

    // One shared counter serves as good-header, slip-wait and window counter.
    localparam int CNT_MAX_A = (LOCK_CNT > WIN_LEN) ? LOCK_CNT : WIN_LEN;
    localparam int CNT_MAX   = (CNT_MAX_A > SLIP_WAIT) ? CNT_MAX_A : SLIP_WAIT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int ERR_W     = $clog2(ERR_CNT + 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [ERR_W-1:0] err_q, err_d, err_inc, err_nx;
    logic [63:0]      data_q, data_d;
    logic [1:0]       hdr_q, hdr_d;
    logic             dvalid_q, dvalid_d;
    logic             lock_q, lock_d;
    logic             slip_q, slip_d;
    logic             herr_q, herr_d;
    logic             hdr_bad;

    always_comb begin
        hdr_bad  = (DATA_IN[65] == DATA_IN[64]);
        cnt_inc  = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
        err_inc  = (err_q == ERR_W'(ERR_CNT)) ? err_q : err_q + 1'b1;
        err_nx   = hdr_bad ? err_inc : err_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        data_d   = data_q;
        hdr_d    = hdr_q;
        dvalid_d = 1'b0;
        slip_d   = 1'b0;
        herr_d   = 1'b0;
        if (DATA_IN_VALID) begin
            data_d   = DATA_IN[66] ? ~DATA_IN[63:0] : DATA_IN[63:0];
            hdr_d    = DATA_IN[65:64];
            herr_d   = hdr_bad;
            dvalid_d = lock_q;
            case (state_q)
                ST_HUNT: begin
                    if (hdr_bad) begin
                        slip_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end else if (cnt_inc >= CNT_W'(LOCK_CNT)) begin
                        cnt_d   = '0;
                        err_d   = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_WAIT: begin
                    if (cnt_inc >= CNT_W'(SLIP_WAIT)) begin
                        cnt_d   = '0;
                        state_d = ST_HUNT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_LOCKED: begin
                    // Lock loss wins over a window clear on the same word.
                    if (err_nx >= ERR_W'(ERR_CNT)) begin
                        slip_d  = 1'b1;
                        cnt_d   = '0;
                        err_d   = '0;
                        state_d = ST_WAIT;
                    end else if (cnt_inc >= CNT_W'(WIN_LEN)) begin
                        cnt_d = '0;
                        err_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        err_d = err_nx;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    err_d   = '0;
                    state_d = ST_HUNT;
                end
            endcase
        end
        lock_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state_q  <= ST_HUNT;
            cnt_q    <= '0;
            err_q    <= '0;
            data_q   <= '0;
            hdr_q    <= '0;
            dvalid_q <= 1'b0;
            lock_q   <= 1'b0;
            slip_q   <= 1'b0;
            herr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            data_q   <= data_d;
            hdr_q    <= hdr_d;
            dvalid_q <= dvalid_d;
            lock_q   <= lock_d;
            slip_q   <= slip_d;
            herr_q   <= herr_d;
        end
    end

    assign DATA_OUT       = data_q;
    assign HEADER_OUT     = hdr_q;
    assign DATA_OUT_VALID = dvalid_q;
    assign BLOCK_LOCK     = lock_q;
    assign SLIP           = slip_q;
    assign HEADER_ERR     = herr_q;

`ifdef DISPARITY_CHECK_EN
    logic signed [15:0] disp_sum_q, disp_sum_d, disp_sum_upd;
    logic               disp_err_q, disp_err_d;
    int                 disp_step;
    int                 disp_val;

    always_comb begin
        disp_step    = 2 * $countones(DATA_IN) - 67;
        disp_sum_upd = disp_sum_q + 16'(disp_step);
        disp_val     = int'(disp_sum_upd);
        disp_sum_d   = disp_sum_q;
        disp_err_d   = 1'b0;
        if (DATA_IN_VALID && (state_q == ST_LOCKED)) begin
            disp_sum_d = disp_sum_upd;
            disp_err_d = (disp_val > DISP_LIMIT) || (disp_val < -DISP_LIMIT);
        end
        // Every entry to or exit from LOCKED restarts the running sum.
        if ((state_q != state_d) && ((state_q == ST_LOCKED) || (state_d == ST_LOCKED))) begin
            disp_sum_d = '0;
        end
    end

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            disp_sum_q <= '0;
            disp_err_q <= 1'b0;
        end else begin
            disp_sum_q <= disp_sum_d;
            disp_err_q <= disp_err_d;
        end
    end

    assign DISP_ERR = disp_err_q;
`endif

endmodule

// File: tb/tb_decode_67b_64b.sv
// Directed bench for decode_67b_64b: a word-level lock model checked every cycle,
// plus literal expectations for lock timing, inversion, slips, windows and async reset.
module tb_decode_67b_64b;

    localparam int LOCK_N  = 64;
    localparam int WIN_N   = 64;
    localparam int ERR_N   = 16;
    localparam int WAIT_N  = 32;
    localparam int DLIMIT  = 128;
    localparam int M_HUNT  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_LOCK  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [66:0] din;
    logic        din_valid;
    logic [63:0] dout;
    logic [1:0]  hout;
    logic        dov, lock, slip, herr;
`ifdef DISPARITY_CHECK_EN
    logic        derr;
`endif

    decode_67b_64b dut (
        .USER_CLK       (clk),
        .SYSTEM_RESET_N (rst_n),
        .DATA_IN        (din),
        .DATA_IN_VALID  (din_valid),
        .DATA_OUT       (dout),
        .HEADER_OUT     (hout),
        .DATA_OUT_VALID (dov),
        .BLOCK_LOCK     (lock),
        .SLIP           (slip),
        .HEADER_ERR     (herr)
`ifdef DISPARITY_CHECK_EN
        ,
        .DISP_ERR       (derr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    bit chk_en = 1'b0;

    // Behavioural model: word-level lock bookkeeping.
    int m_mode, m_good, m_wait_left, m_win, m_errs, m_sum;
    logic [63:0] exp_data;
    logic [1:0]  exp_hdr;
    bit          exp_dv, exp_lock, exp_slip, exp_herr, exp_disp;

    task automatic model_reset();
        m_mode = M_HUNT; m_good = 0; m_wait_left = 0; m_win = 0; m_errs = 0; m_sum = 0;
        exp_data = '0; exp_hdr = '0;
        exp_dv = 0; exp_lock = 0; exp_slip = 0; exp_herr = 0; exp_disp = 0;
    endtask

    task automatic model_word(input bit v, input logic [66:0] d);
        bit bad;
        bad = (d[65:64] == 2'b00) || (d[65:64] == 2'b11);
        exp_dv = 0; exp_slip = 0; exp_herr = 0; exp_disp = 0;
        if (v) begin
            exp_dv   = (m_mode == M_LOCK);
            exp_data = d[66] ? ~d[63:0] : d[63:0];
            exp_hdr  = d[65:64];
            exp_herr = bad;
            if (m_mode == M_LOCK) begin
                m_sum    = m_sum + 2 * $countones(d) - 67;
                exp_disp = (m_sum > DLIMIT) || (m_sum < -DLIMIT);
            end
            if (m_mode == M_HUNT) begin
                if (bad) begin
                    exp_slip = 1; m_mode = M_WAIT; m_wait_left = WAIT_N;
                end else begin
                    m_good++;
                    if (m_good == LOCK_N) begin
                        m_mode = M_LOCK; m_win = 0; m_errs = 0; m_sum = 0;
                    end
                end
            end else if (m_mode == M_WAIT) begin
                m_wait_left--;
                if (m_wait_left == 0) begin
                    m_mode = M_HUNT; m_good = 0;
                end
            end else begin
                m_win++;
                if (bad) m_errs++;
                if (m_errs == ERR_N) begin
                    exp_slip = 1; m_mode = M_WAIT; m_wait_left = WAIT_N; m_sum = 0;
                end else if (m_win == WIN_N) begin
                    m_win = 0; m_errs = 0;
                end
            end
        end
        exp_lock = (m_mode == M_LOCK);
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model, just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            cmp("model_data", dout, exp_data);
            cmp("model_hdr", {62'd0, hout}, {62'd0, exp_hdr});
            cmp("model_dv", {63'd0, dov}, {63'd0, exp_dv});
            cmp("model_lock", {63'd0, lock}, {63'd0, exp_lock});
            cmp("model_slip", {63'd0, slip}, {63'd0, exp_slip});
            cmp("model_herr", {63'd0, herr}, {63'd0, exp_herr});
`ifdef DISPARITY_CHECK_EN
            cmp("model_disp", {63'd0, derr}, {63'd0, exp_disp});
`endif
        end
    end

    task automatic step(input bit v, input logic [66:0] d);
        din_valid = v;
        din       = d;
        model_word(v, d);
        @(posedge clk);
        @(negedge clk);
        txn++;
        $display("txn %0d v=%0b in=%h out=%h hdr=%b dv=%b lock=%b slip=%b herr=%b",
                 txn, v, d, dout, hout, dov, lock, slip, herr);
    endtask

    function automatic logic [66:0] good_word();
        logic [1:0] h;
        h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        return {1'($urandom_range(0, 1)), h, $urandom, $urandom};
    endfunction

    function automatic logic [66:0] bad_word(input int i);
        logic [1:0] h;
        h = (i % 2 == 0) ? 2'b00 : 2'b11;
        return {1'($urandom_range(0, 1)), h, $urandom, $urandom};
    endfunction

    task automatic lock_up(input string tag);
        for (int i = 0; i < LOCK_N; i++) begin
            step(1, good_word());
            if (i == LOCK_N - 2) cmp({tag, "_lock_at63"}, {63'd0, lock}, 64'd0);
            if (i == LOCK_N - 1) begin
                cmp({tag, "_lock_at64"}, {63'd0, lock}, 64'd1);
                cmp({tag, "_dv_word64"}, {63'd0, dov}, 64'd0);
            end
        end
    endtask

    int slip_seen;

    initial begin
        model_reset();
        rst_n     = 1'b0;
        din_valid = 1'b1;
        din       = {1'b1, 2'b11, 64'hFFFF_0000_FFFF_0000};
        repeat (3) @(negedge clk);
        cmp("rst_data", dout, 64'd0);
        cmp("rst_flags", {58'd0, hout, dov, lock, slip, herr}, 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Initial lock with an idle cycle mixed in; outputs must hold through it.
        for (int i = 0; i < LOCK_N; i++) begin
            if (i == 5) step(0, bad_word(0));
            step(1, {1'b0, 2'b01, $urandom, $urandom});
            if (i == LOCK_N - 2) cmp("lock_at63", {63'd0, lock}, 64'd0);
            if (i == LOCK_N - 1) begin
                cmp("lock_at64", {63'd0, lock}, 64'd1);
                cmp("dv_word64", {63'd0, dov}, 64'd0);
            end
        end
        step(1, {1'b0, 2'b01, 64'h0123_4567_89AB_CDEF});
        cmp("dv_word65", {63'd0, dov}, 64'd1);
        cmp("data_word65", dout, 64'h0123_4567_89AB_CDEF);

        step(1, {1'b1, 2'b10, 64'h0000_0000_FFFF_FFFF});
        cmp("inv_data", dout, 64'hFFFF_FFFF_0000_0000);
        cmp("inv_hdr", {62'd0, hout}, 64'd2);

        // Finish the first window, then 15 errors at the tail of the next one.
        for (int i = 0; i < WIN_N - 2; i++) step(1, good_word());
        for (int i = 0; i < WIN_N; i++) step(1, (i >= 49) ? bad_word(i) : good_word());
        cmp("lock_after_15err", {63'd0, lock}, 64'd1);
        // 16th error lands on the last word of the window.
        for (int i = 0; i < WIN_N; i++) begin
            step(1, (i >= 48) ? bad_word(i) : good_word());
            if (i == WIN_N - 2) cmp("lock_before_16th", {63'd0, lock}, 64'd1);
        end
        cmp("lock_after_16err", {63'd0, lock}, 64'd0);
        cmp("slip_on_16th", {63'd0, slip}, 64'd1);

        slip_seen = 0;
        for (int i = 0; i < WAIT_N; i++) begin
            step(1, bad_word(i));
            slip_seen += int'(slip);
        end
        cmp("wait_no_slip", 64'(slip_seen), 64'd0);

        // Bad header on the 10th word while hunting.
        for (int i = 1; i <= 10; i++) step(1, (i == 10) ? {1'b0, 2'b11, 64'h5555} : good_word());
        cmp("hunt_slip", {63'd0, slip}, 64'd1);
        cmp("hunt_herr", {63'd0, herr}, 64'd1);
        slip_seen = 0;
        for (int i = 0; i < WAIT_N; i++) begin
            step(1, bad_word(i + 1));
            slip_seen += int'(slip);
        end
        cmp("wait2_no_slip", 64'(slip_seen), 64'd0);
        lock_up("relock1");

        // Asynchronous reset mid-lock with the input qualifier toggling.
        for (int i = 0; i < 5; i++) step(1, good_word());
        chk_en    = 1'b0;
        rst_n     = 1'b0;
        din_valid = 1'b1;
        din       = good_word();
        #1;
        cmp("async_rst_data", dout, 64'd0);
        cmp("async_rst_flags", {58'd0, hout, dov, lock, slip, herr}, 64'd0);
        #2 din_valid = 1'b0;
        #4 din_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        lock_up("relock2");

`ifdef DISPARITY_CHECK_EN
        for (int i = 1; i <= 3; i++) begin
            step(1, {1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF});
            cmp($sformatf("disp_word%0d", i), {63'd0, derr}, (i == 3) ? 64'd1 : 64'd0);
        end
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
